// File: rtl/sprint_gear_ctrl_if.sv
// Button inputs, gear outputs and shift pulses shared by the gear-shift
// controller and whatever drives it. Names are from the controller's side.
interface sprint_gear_ctrl_if;
   logic       i_clear;        // game-start clear, forces both players to gear index 0
   logic [1:0] i_up;           // raw gear-up buttons, bit = player
   logic [1:0] i_down;         // raw gear-down buttons, bit = player
   logic [3:0] o_gear_idx;     // [1:0] = P1, [3:2] = P2
   logic [1:0] o_gear1_n;      // active-low gear switch lines, bit = player
   logic [1:0] o_gear2_n;
   logic [1:0] o_gear3_n;
   logic [1:0] o_shift_pulse;  // one-cycle pulse per accepted shift

   // Stimulus / joystick-mapping side
   modport master (
      output i_clear, i_up, i_down,
      input  o_gear_idx, o_gear1_n, o_gear2_n, o_gear3_n, o_shift_pulse
   );

   // Gear controller side
   modport slave (
      input  i_clear, i_up, i_down,
      output o_gear_idx, o_gear1_n, o_gear2_n, o_gear3_n, o_shift_pulse
   );
endinterface

// File: rtl/sprint_gear_ctrl.sv
// Two-player gear-shift controller: each player's raw up/down buttons are
// debounced, rising-edge detected and turned into a saturating 4-position
// gear register, with a post-shift holdoff and a synchronous game-start
// clear. The gear register drives the active-low gear1/2/3 switch lines.
module sprint_gear_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,   // 1..65535
   parameter int SHIFT_HOLDOFF   = 1024  // 0..65535, 0 disables holdoff
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   sprint_gear_ctrl_if.slave bus
);

   // Counter value at which a persistent raw difference is accepted
   localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
   // Holdoff load value after an accepted shift
   localparam logic [15:0] HOLD_LEN = 16'(SHIFT_HOLDOFF);

   logic [3:0] w_gear_idx;
   logic [1:0] w_gear1_n;
   logic [1:0] w_gear2_n;
   logic [1:0] w_gear3_n;
   logic [1:0] w_shift_pulse;

   genvar gi, gj;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_player
         // Button index inside a player: 0 = up, 1 = down
         logic [1:0]  w_raw;
         logic [1:0]  w_rise;
         logic [1:0]  r_gear;
         logic [1:0]  w_gear_next;
         logic [15:0] r_hold;
         logic [15:0] w_hold_next;
         logic        r_pulse;
         logic        w_pulse_next;

         assign w_raw = {bus.i_down[gi], bus.i_up[gi]};

         for (gj = 0; gj < 2; gj++) begin : g_btn
            logic [15:0] r_cnt;
            logic        r_filt;
            logic        r_prev;

            // Debounce filter: follow raw only after it differs for DEBOUNCE_CYCLES
            // samples; prev keeps running during clear so held buttons never re-fire
            always_ff @(posedge i_clk or negedge i_reset_n) begin
               if (!i_reset_n) begin
                  r_cnt  <= '0;
                  r_filt <= 1'b0;
                  r_prev <= 1'b0;
               end else begin
                  r_prev <= r_filt;
                  if (w_raw[gj] == r_filt) begin
                     r_cnt <= '0;
                  end else if (r_cnt == DB_LAST) begin
                     r_filt <= w_raw[gj];
                     r_cnt  <= '0;
                  end else begin
                     r_cnt <= r_cnt + 16'd1;
                  end
               end
            end

            // Only rising filtered edges request a shift
            assign w_rise[gj] = r_filt & ~r_prev;
         end

         // Shift decision in priority order: clear, simultaneous up+down,
         // holdoff, then saturating up/down
         always_comb begin
            w_gear_next  = r_gear;
            w_pulse_next = 1'b0;
            w_hold_next  = (r_hold != 16'd0) ? (r_hold - 16'd1) : 16'd0;
            if (bus.i_clear) begin
               w_gear_next = 2'd0;
               w_hold_next = 16'd0;
            end else if (w_rise[0] && w_rise[1]) begin
               // conflicting requests cancel each other
            end else if (r_hold != 16'd0) begin
               // inside the post-shift window: edge dropped, not queued
            end else if (w_rise[0] && (r_gear != 2'd3)) begin
               w_gear_next  = r_gear + 2'd1;
               w_pulse_next = 1'b1;
               w_hold_next  = HOLD_LEN;
            end else if (w_rise[1] && (r_gear != 2'd0)) begin
               w_gear_next  = r_gear - 2'd1;
               w_pulse_next = 1'b1;
               w_hold_next  = HOLD_LEN;
            end
         end

         // Gear, holdoff and pulse registers
         always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
               r_gear  <= 2'd0;
               r_hold  <= 16'd0;
               r_pulse <= 1'b0;
            end else begin
               r_gear  <= w_gear_next;
               r_hold  <= w_hold_next;
               r_pulse <= w_pulse_next;
            end
         end

         // Switch decode straight from the gear register, no added latency
         assign w_gear_idx[2*gi +: 2] = r_gear;
         assign w_gear1_n[gi]         = (r_gear != 2'd0);
         assign w_gear2_n[gi]         = (r_gear != 2'd1);
         assign w_gear3_n[gi]         = (r_gear != 2'd2);
         assign w_shift_pulse[gi]     = r_pulse;
      end
   endgenerate

   assign bus.o_gear_idx    = w_gear_idx;
   assign bus.o_gear1_n     = w_gear1_n;
   assign bus.o_gear2_n     = w_gear2_n;
   assign bus.o_gear3_n     = w_gear3_n;
   assign bus.o_shift_pulse = w_shift_pulse;

endmodule

// File: tb/tb_sprint_gear_ctrl.sv
// Directed bench for sprint_gear_ctrl with DEBOUNCE_CYCLES=4, SHIFT_HOLDOFF=8.
// Every accepted shift is predicted when its stimulus is driven and checked
// against the DUT's shift pulses by a negedge scoreboard monitor.
module tb_sprint_gear_ctrl;

   typedef struct {
      int         edge_no;
      int         player;
      logic [1:0] gear;
   } exp_t;

   exp_t sb[$];

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   sprint_gear_ctrl_if bus ();

   sprint_gear_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .SHIFT_HOLDOFF   (8)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Edge counter: value N after the N-th active edge following reset release
   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] gear_of(input int p);
      return bus.o_gear_idx[2*p +: 2];
   endfunction

   // {gear1_n, gear2_n, gear3_n} for one player
   function automatic logic [2:0] lines_of(input int p);
      return {bus.o_gear1_n[p], bus.o_gear2_n[p], bus.o_gear3_n[p]};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int e, input int p, input logic [1:0] g);
      exp_t x;
      x.edge_no = e;
      x.player  = p;
      x.gear    = g;
      sb.push_back(x);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_gear_idx"}, 32'(bus.o_gear_idx), 32'h0);
      check({tag, "_gear1_n"}, 32'(bus.o_gear1_n), 32'h0);
      check({tag, "_gear2_n"}, 32'(bus.o_gear2_n), 32'h3);
      check({tag, "_gear3_n"}, 32'(bus.o_gear3_n), 32'h3);
      check({tag, "_pulse"}, 32'(bus.o_shift_pulse), 32'h0);
   endtask

   // One clean press: held 6 cycles, released 14 (covers release debounce and holdoff)
   task automatic press(input int p, input bit dn, input bit accept, input logic [1:0] exp_gear);
      $display("[TB] press P%0d %s at edge %0d, expect gear %0d%s", p + 1, dn ? "down" : "up",
               cyc, exp_gear, accept ? "" : " (discarded)");
      if (dn) bus.i_down[p] = 1'b1;
      else    bus.i_up[p]   = 1'b1;
      if (accept) push_exp(cyc + 5, p, exp_gear);
      tick(6);
      check($sformatf("press_p%0d_gear", p + 1), 32'(gear_of(p)), 32'(exp_gear));
      bus.i_up[p]   = 1'b0;
      bus.i_down[p] = 1'b0;
      tick(14);
   endtask

   // Scoreboard monitor: every shift pulse must match the next prediction
   always @(negedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (bus.o_shift_pulse[p] === 1'b1) begin : got_pulse
            exp_t e;
            if (sb.size() == 0) begin
               check("pulse_unexpected", 32'(bus.o_shift_pulse[p]), 32'h0);
            end else begin
               e = sb.pop_front();
               $display("[TB] pulse P%0d gear %0d at edge %0d (expected P%0d gear %0d at edge %0d)",
                        p + 1, gear_of(p), cyc, e.player + 1, e.gear, e.edge_no);
               check("pulse_player", 32'(p), 32'(e.player));
               check("pulse_edge", 32'(cyc), 32'(e.edge_no));
               check("pulse_gear", 32'(gear_of(p)), 32'(e.gear));
            end
         end
      end
   end

   initial begin
      bus.i_clear = 1'b0;
      bus.i_up    = 2'b00;
      bus.i_down  = 2'b00;

      // Reset and idle
      tick(3);
      check_reset("rst");
      rst_n = 1'b1;
      tick(20);
      check_reset("idle");

      // P1 up held: shift exactly DEBOUNCE_CYCLES edges after first sample
      $display("[TB] P1 up held from edge %0d", cyc + 1);
      bus.i_up[0] = 1'b1;
      push_exp(cyc + 5, 0, 2'd1);
      tick(4);
      check("p1_not_yet", 32'(bus.o_gear_idx), 32'h0);
      tick(1);
      check("p1_first_shift", 32'(bus.o_gear_idx), 32'h1);
      check("p1_lines_idx1", 32'(lines_of(0)), 32'b101);
      check("p2_lines_idx0", 32'(lines_of(1)), 32'b011);
      tick(5);
      bus.i_up[0] = 1'b0;
      tick(20);

      // Glitch of 3 cycles is filtered out
      $display("[TB] P1 up glitch of 3 cycles at edge %0d", cyc + 1);
      bus.i_up[0] = 1'b1;
      tick(3);
      bus.i_up[0] = 1'b0;
      tick(12);
      check("p1_glitch", 32'(bus.o_gear_idx), 32'h1);

      // Back to 0, then up saturation and down saturation
      press(0, 1'b1, 1'b1, 2'd0);
      press(0, 1'b0, 1'b1, 2'd1);
      press(0, 1'b0, 1'b1, 2'd2);
      press(0, 1'b0, 1'b1, 2'd3);
      check("p1_lines_idx3", 32'(lines_of(0)), 32'b111);
      press(0, 1'b0, 1'b0, 2'd3);
      press(0, 1'b1, 1'b1, 2'd2);
      check("p1_lines_idx2", 32'(lines_of(0)), 32'b110);
      press(0, 1'b1, 1'b1, 2'd1);
      press(0, 1'b1, 1'b1, 2'd0);
      press(0, 1'b1, 1'b0, 2'd0);
      press(0, 1'b1, 1'b0, 2'd0);

      // Holdoff: down rise 5 edges after an accepted shift is discarded
      $display("[TB] holdoff: rise at shift+5");
      bus.i_up[0] = 1'b1;
      push_exp(cyc + 5, 0, 2'd1);
      tick(5);
      bus.i_down[0] = 1'b1;
      tick(6);
      check("hold_plus5", 32'(gear_of(0)), 32'd1);
      bus.i_up[0]   = 1'b0;
      bus.i_down[0] = 1'b0;
      tick(20);

      // Holdoff boundary: rise at shift+8 discarded
      $display("[TB] holdoff: rise at shift+8");
      bus.i_up[0] = 1'b1;
      push_exp(cyc + 5, 0, 2'd2);
      tick(8);
      bus.i_down[0] = 1'b1;
      tick(6);
      check("hold_plus8", 32'(gear_of(0)), 32'd2);
      bus.i_up[0]   = 1'b0;
      bus.i_down[0] = 1'b0;
      tick(20);

      // Holdoff boundary: rise at shift+9 accepted
      $display("[TB] holdoff: rise at shift+9");
      bus.i_up[0] = 1'b1;
      push_exp(cyc + 5, 0, 2'd3);
      tick(9);
      bus.i_down[0] = 1'b1;
      push_exp(cyc + 5, 0, 2'd2);
      tick(6);
      check("hold_plus9", 32'(gear_of(0)), 32'd2);
      bus.i_up[0]   = 1'b0;
      bus.i_down[0] = 1'b0;
      tick(20);

      // P2 to index 1, then simultaneous up+down on P2 while P1 shifts up
      press(1, 1'b0, 1'b1, 2'd1);
      $display("[TB] P2 up+down together, P1 up concurrently");
      bus.i_up[1]   = 1'b1;
      bus.i_down[1] = 1'b1;
      bus.i_up[0]   = 1'b1;
      push_exp(cyc + 5, 0, 2'd3);
      tick(6);
      check("p2_both_gear", 32'(gear_of(1)), 32'd1);
      check("p2_lines_idx1", 32'(lines_of(1)), 32'b101);
      check("p1_concurrent_gear", 32'(gear_of(0)), 32'd3);
      bus.i_up   = 2'b00;
      bus.i_down = 2'b00;
      tick(14);

      // Clear overrides a same-cycle shift and a held button does not re-shift
      press(0, 1'b1, 1'b1, 2'd2);
      $display("[TB] clear coinciding with P1 up rise at gear 2");
      bus.i_up[0] = 1'b1;
      tick(4);
      bus.i_clear = 1'b1;
      tick(1);
      bus.i_clear = 1'b0;
      check("clear_gear_idx", 32'(bus.o_gear_idx), 32'h0);
      tick(20);
      check("clear_no_reshift", 32'(bus.o_gear_idx), 32'h0);
      bus.i_up[0] = 1'b0;
      tick(14);

      // Clear also cancels a running holdoff
      $display("[TB] clear during holdoff, rise at shift+8 accepted");
      bus.i_up[0] = 1'b1;
      push_exp(cyc + 5, 0, 2'd1);
      tick(4);
      bus.i_up[0] = 1'b0;
      tick(1);
      bus.i_clear = 1'b1;
      tick(1);
      bus.i_clear = 1'b0;
      check("clear_in_hold", 32'(gear_of(0)), 32'd0);
      tick(2);
      bus.i_up[0] = 1'b1;
      push_exp(cyc + 5, 0, 2'd1);
      tick(5);
      check("after_clear_hold", 32'(gear_of(0)), 32'd1);
      bus.i_up[0] = 1'b0;
      tick(14);

      // Asynchronous reset mid-debounce
      $display("[TB] async reset mid-debounce");
      bus.i_up[0] = 1'b1;
      tick(2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("async_rst");
      bus.i_up[0] = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(10);
      check_reset("post_rst");

      check("sb_drain", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
